mem_access: RTL

Memory-access (MEM) stage of the five-stage pipeline, between the EX/MEM register and the MEM/WB register. It issues loads and stores to the data-side SRAM-like bus and builds byte strobes and replicated write data. It also aligns and extends load data, detects address errors, and requests a pipeline stall until the bus transaction completes. Its outputs are the `i_*` inputs of the MEM/WB register.

---
 rtl/mem_access_pkg.sv | 40 ++++
 rtl/mem_align.sv | 78 +++++++
 rtl/mem_access.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: memory-op encodings, stall levels,
// zero constants and FSM state encodings.
package mem_access_pkg;

  localparam int unsigned MemOpW = 4;

  localparam logic [MemOpW-1:0] MemOpNone = MemOpW'(0);
  localparam logic [MemOpW-1:0] MemOpLb   = MemOpW'(1);
  localparam logic [MemOpW-1:0] MemOpLbu  = MemOpW'(2);
  localparam logic [MemOpW-1:0] MemOpLh   = MemOpW'(3);
  localparam logic [MemOpW-1:0] MemOpLhu  = MemOpW'(4);
  localparam logic [MemOpW-1:0] MemOpLw   = MemOpW'(5);
  localparam logic [MemOpW-1:0] MemOpSb   = MemOpW'(6);
  localparam logic [MemOpW-1:0] MemOpSh   = MemOpW'(7);
  localparam logic [MemOpW-1:0] MemOpSw   = MemOpW'(8);

  localparam logic        Stop     = 1'b1;
  localparam logic        NoStop   = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic        ZeroBit  = 1'b0;

  // Index of the MEM-stage hold bit inside the pipeline stall vector.
  localparam int unsigned StallMemBit = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StDone = 2'd3
  } mem_state_e;

  function automatic logic op_is_load(logic [MemOpW-1:0] op);
    return op inside {MemOpLb, MemOpLbu, MemOpLh, MemOpLhu, MemOpLw};
  endfunction

  function automatic logic op_is_store(logic [MemOpW-1:0] op);
    return op inside {MemOpSb, MemOpSh, MemOpSw};
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store strobes/replication, load lane select and
// extension, access size and alignment check.
module mem_align
  import mem_access_pkg::*;
(
  input  logic [MemOpW-1:0] op,
  input  logic [1:0]        addr_lo,
  input  logic [31:0]       store_data,
  input  logic [31:0]       rdata,
  output logic [3:0]        wstrb,
  output logic [31:0]       wdata,
  output logic [1:0]        size,
  output logic [31:0]       load_data,
  output logic              misalign
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    unique case (addr_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    wstrb     = 4'b0000;
    wdata     = ZeroWord;
    size      = 2'd0;
    load_data = ZeroWord;
    misalign  = ZeroBit;
    case (op)
      MemOpLb: begin
        load_data = {{24{lane_b[7]}}, lane_b};
      end
      MemOpLbu: begin
        load_data = {24'h00_0000, lane_b};
      end
      MemOpLh: begin
        size      = 2'd1;
        misalign  = addr_lo[0];
        load_data = {{16{lane_h[15]}}, lane_h};
      end
      MemOpLhu: begin
        size      = 2'd1;
        misalign  = addr_lo[0];
        load_data = {16'h0000, lane_h};
      end
      MemOpLw: begin
        size      = 2'd2;
        misalign  = |addr_lo;
        load_data = rdata;
      end
      MemOpSb: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      MemOpSh: begin
        size     = 2'd1;
        misalign = addr_lo[0];
        wstrb    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{store_data[15:0]}};
      end
      MemOpSw: begin
        size     = 2'd2;
        misalign = |addr_lo;
        wstrb    = 4'b1111;
        wdata    = store_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: drives the SRAM-like data bus, stalls the pipeline until
// the transaction completes, and presents aligned results to MEM/WB.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned MEMOP_W = MemOpW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         stall,
  input  logic [31:0]        i_alu_res,
  input  logic [31:0]        i_store_data,
  input  logic [4:0]         i_rn,
  input  logic               i_write_regfile,
  input  logic [MEMOP_W-1:0] i_mem_op,
  output logic               data_req,
  output logic               data_wr,
  output logic [1:0]         data_size,
  output logic [31:0]        data_addr,
  output logic [3:0]         data_wstrb,
  output logic [31:0]        data_wdata,
  input  logic               data_addr_ok,
  input  logic               data_data_ok,
  input  logic [31:0]        data_rdata,
  output logic [31:0]        o_d1,
  output logic [31:0]        o_d2,
  output logic [4:0]         o_rn,
  output logic               o_write_regfile,
  output logic               o_mem_to_regfile,
  output logic               o_stallreq,
  output logic               o_adel,
  output logic               o_ades,
  output logic [31:0]        o_badvaddr
);

  mem_state_e state_q, state_d;
  logic [31:0] rbuf_q, rbuf_d;

  logic [MemOpW-1:0] op;
  logic        is_load, is_store, issue;
  logic        misalign;
  logic [3:0]  wstrb;
  logic [31:0] wdata, load_data;
  logic [1:0]  size;
  logic        req_c, stall_c;
  logic        unused_stall;

  assign op           = MemOpW'(i_mem_op);
  assign is_load      = op_is_load(op);
  assign is_store     = op_is_store(op);
  assign issue        = (is_load | is_store) & ~misalign;
  assign unused_stall = ^{stall[5], stall[3:0]};

  // Loads align the buffered word, so o_d2 stays valid for as long as DONE is held.
  mem_align u_align (
    .op         (op),
    .addr_lo    (i_alu_res[1:0]),
    .store_data (i_store_data),
    .rdata      (rbuf_q),
    .wstrb      (wstrb),
    .wdata      (wdata),
    .size       (size),
    .load_data  (load_data),
    .misalign   (misalign)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      rbuf_q  <= ZeroWord;
    end else begin
      state_q <= state_d;
      rbuf_q  <= rbuf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rbuf_d  = rbuf_q;
    req_c   = 1'b0;
    stall_c = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          req_c   = 1'b1;
          stall_c = 1'b1;
          state_d = data_addr_ok ? StWait : StReq;
        end
      end
      StReq: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (data_addr_ok) state_d = StWait;
      end
      StWait: begin
        stall_c = 1'b1;
        if (data_data_ok) begin
          rbuf_d  = data_rdata;
          state_d = StDone;
        end
      end
      StDone: begin
        if (stall[StallMemBit] == NoStop) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Every output is forced low while reset is asserted.
  always_comb begin
    data_req         = ZeroBit;
    data_wr          = ZeroBit;
    data_size        = 2'd0;
    data_addr        = ZeroWord;
    data_wstrb       = 4'b0000;
    data_wdata       = ZeroWord;
    o_d1             = ZeroWord;
    o_d2             = ZeroWord;
    o_rn             = 5'd0;
    o_write_regfile  = ZeroBit;
    o_mem_to_regfile = ZeroBit;
    o_stallreq       = ZeroBit;
    o_adel           = ZeroBit;
    o_ades           = ZeroBit;
    o_badvaddr       = ZeroWord;
    if (reset) begin
      data_req         = req_c;
      data_wr          = is_store;
      data_size        = size;
      data_addr        = i_alu_res;
      data_wstrb       = wstrb;
      data_wdata       = wdata;
      o_d1             = i_alu_res;
      o_d2             = (state_q == StDone) ? load_data : ZeroWord;
      o_rn             = i_rn;
      o_write_regfile  = i_write_regfile & ~misalign;
      o_mem_to_regfile = is_load;
      o_stallreq       = stall_c;
      o_adel           = is_load & misalign;
      o_ades           = is_store & misalign;
      o_badvaddr       = misalign ? i_alu_res : ZeroWord;
    end
  end

endmodule
